// File: rtl/encoder_defs.sv
// Shared definitions for the request encoder family: FSM state encodings
// and a constant-evaluable clog2 used for parameter checks.
package encoder_defs;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_HOLD  = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational picker: first set bit of mask, either circularly after ptr
// (round-robin) or lowest index first (fixed priority).
module rr_priority_pick #(
  parameter int N_IN   = 4,
  parameter int CODE_W = 2
) (
  input  logic [N_IN-1:0]   mask,
  input  logic [CODE_W-1:0] ptr,
  input  logic              rr_en,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  logic [CODE_W-1:0] cand;
  logic              found;

  // N_IN is a power of two, so CODE_W-bit addition wraps the search circularly.
  always_comb begin
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    any   = |mask;
    for (int k = 0; k < N_IN; k++) begin
      cand = rr_en ? CODE_W'(ptr + CODE_W'(k) + CODE_W'(1)) : CODE_W'(k);
      if (!found && mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_encoder_4to2.sv
// Request encoder: captures request strobes into a pending mask and emits one
// binary index per served request on a valid/ready output.
module req_encoder_4to2
  import encoder_defs::*;
#(
  parameter int N_IN   = 4,
  parameter int CODE_W = 2,
  parameter int RR_EN  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [N_IN-1:0]   req_in,
  output logic [CODE_W-1:0] code_out,
  output logic              code_valid,
  input  logic              code_ready,
  output logic [N_IN-1:0]   pending_out,
  output logic              overflow,
  output logic              state_dbg
);

  if (CODE_W != clog2(N_IN)) begin : g_bad_code_w
    $error("req_encoder_4to2: CODE_W must equal clog2(N_IN)");
  end

  localparam logic RR_BIT = (RR_EN != 0);
  localparam logic [N_IN-1:0] ONE_HOT0 = {{(N_IN-1){1'b0}}, 1'b1};

  logic              state;
  logic [N_IN-1:0]   pending;
  logic [CODE_W-1:0] ptr;
  logic [CODE_W-1:0] pick;
  logic              any;
  logic              load;
  logic [N_IN-1:0]   loaded_mask;
  logic              ovf_hit;

  rr_priority_pick #(
    .N_IN   (N_IN),
    .CODE_W (CODE_W)
  ) u_pick (
    .mask  (pending),
    .ptr   (ptr),
    .rr_en (RR_BIT),
    .idx   (pick),
    .any   (any)
  );

  // Handshake: code_out is a transfer when code_valid && code_ready on a
  // rising edge; while code_valid is high and code_ready low, code_out holds.
  assign load        = ((state == ST_EMPTY) || code_ready) && any;
  assign loaded_mask = load ? (ONE_HOT0 << pick) : '0;
  // A bit being loaded this edge may be re-requested without counting as lost.
  assign ovf_hit     = |(req_in & pending & ~loaded_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      pending  <= '0;
      code_out <= '0;
      ptr      <= '1;
      overflow <= 1'b0;
    end else if (clear) begin
      state    <= ST_EMPTY;
      pending  <= '0;
      code_out <= '0;
      ptr      <= '1;
      overflow <= 1'b0;
    end else begin
      pending <= (pending & ~loaded_mask) | req_in;
      if (ovf_hit) overflow <= 1'b1;
      if (load) begin
        code_out <= pick;
        state    <= ST_HOLD;
        ptr      <= pick;
      end else if ((state == ST_HOLD) && code_ready) begin
        state <= ST_EMPTY;
      end
    end
  end

  assign code_valid  = (state == ST_HOLD);
  assign pending_out = pending;
  assign state_dbg   = state;

endmodule

// File: tb/tb_req_encoder_4to2.sv
// Bench for req_encoder_4to2: a round-robin and a fixed-priority instance
// share stimulus and are compared every cycle against an arithmetic model.
module tb_req_encoder_4to2;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [3:0] req_in;
  logic       code_ready;

  logic [1:0] code_out_w   [2];
  logic       code_valid_w [2];
  logic [3:0] pending_w    [2];
  logic       overflow_w   [2];
  logic       state_w      [2];

  int tests_run;
  int tests_failed;

  // model state, index 0 = round-robin DUT, index 1 = fixed-priority DUT
  int m_pend  [2];
  int m_code  [2];
  int m_ptr   [2];
  bit m_valid [2];
  bit m_ovf   [2];

  req_encoder_4to2 #(.N_IN(4), .CODE_W(2), .RR_EN(1)) dut_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .req_in      (req_in),
    .code_out    (code_out_w[0]),
    .code_valid  (code_valid_w[0]),
    .code_ready  (code_ready),
    .pending_out (pending_w[0]),
    .overflow    (overflow_w[0]),
    .state_dbg   (state_w[0])
  );

  req_encoder_4to2 #(.N_IN(4), .CODE_W(2), .RR_EN(0)) dut_fp (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .req_in      (req_in),
    .code_out    (code_out_w[1]),
    .code_valid  (code_valid_w[1]),
    .code_ready  (code_ready),
    .pending_out (pending_w[1]),
    .overflow    (overflow_w[1]),
    .state_dbg   (state_w[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_fn(input int pend, input int ptr, input bit rr);
    int i;
    for (int k = 1; k <= 4; k++) begin
      i = rr ? (ptr + k) % 4 : k - 1;
      if (((pend >> i) & 1) == 1) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pend[d]  = 0;
      m_code[d]  = 0;
      m_ptr[d]   = 3;
      m_valid[d] = 1'b0;
      m_ovf[d]   = 1'b0;
    end
  endtask

  task automatic model_step(input logic [3:0] r, input logic rdy, input logic clr);
    int p;
    bit ld;
    for (int d = 0; d < 2; d++) begin
      if (clr) begin
        m_pend[d]  = 0;
        m_code[d]  = 0;
        m_ptr[d]   = 3;
        m_valid[d] = 1'b0;
        m_ovf[d]   = 1'b0;
      end else begin
        p  = pick_fn(m_pend[d], m_ptr[d], d == 0);
        ld = (!m_valid[d] || rdy) && (m_pend[d] != 0);
        for (int i = 0; i < 4; i++)
          if (r[i] && (((m_pend[d] >> i) & 1) == 1) && !(ld && p == i)) m_ovf[d] = 1'b1;
        if (ld) m_pend[d] = m_pend[d] & ~(1 << p);
        m_pend[d] = m_pend[d] | int'(r);
        if (ld) begin
          m_code[d]  = p;
          m_valid[d] = 1'b1;
          m_ptr[d]   = p;
        end else if (m_valid[d] && rdy) begin
          m_valid[d] = 1'b0;
        end
      end
    end
  endtask

  // scoreboard: every observable output of both DUTs against the model
  task automatic check_all(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s[%0d].code_out", tag, d),   32'(code_out_w[d]),   32'(m_code[d]));
      chk($sformatf("%s[%0d].code_valid", tag, d), 32'(code_valid_w[d]), 32'(m_valid[d]));
      chk($sformatf("%s[%0d].pending", tag, d),    32'(pending_w[d]),    32'(m_pend[d]));
      chk($sformatf("%s[%0d].overflow", tag, d),   32'(overflow_w[d]),   32'(m_ovf[d]));
      chk($sformatf("%s[%0d].state", tag, d),      32'(state_w[d]),      32'(m_valid[d]));
    end
  endtask

  // driver: apply inputs just after an edge, then check after the next edge
  task automatic cycle(input string tag, input logic [3:0] r, input logic rdy, input logic clr);
    req_in     = r;
    code_ready = rdy;
    clear      = clr;
    @(posedge clk);
    model_step(r, rdy, clr);
    #1;
    check_all(tag);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n      = 1'b0;
    clear      = 1'b0;
    req_in     = '0;
    code_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    check_all("reset");
    rst_n = 1'b1;
    cycle("idle", 4'b0000, 1'b1, 1'b0);

    // single request: code 2 two edges after the strobe, for one cycle
    cycle("t1_req", 4'b0100, 1'b1, 1'b0);
    chk("t1_valid_early", 32'(code_valid_w[0]), 32'd0);
    cycle("t1_out", 4'b0000, 1'b1, 1'b0);
    chk("t1_code", 32'(code_out_w[0]), 32'd2);
    chk("t1_valid", 32'(code_valid_w[0]), 32'd1);
    chk("t1_pending", 32'(pending_w[0]), 32'd0);
    cycle("t1_done", 4'b0000, 1'b1, 1'b0);
    chk("t1_valid_drop", 32'(code_valid_w[0]), 32'd0);

    // all four lines at once: 0,1,2,3 back to back, no overflow
    cycle("t2_clr", 4'b0000, 1'b1, 1'b1);
    cycle("t2_req", 4'b1111, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle("t2_drain", 4'b0000, 1'b1, 1'b0);
      chk($sformatf("t2_code%0d", k), 32'(code_out_w[0]), 32'(k));
      chk($sformatf("t2_valid%0d", k), 32'(code_valid_w[0]), 32'd1);
      chk($sformatf("t2_ovf%0d", k), 32'(overflow_w[0]), 32'd0);
    end
    cycle("t2_tail", 4'b0000, 1'b1, 1'b0);

    // fixed priority with a held request pattern
    cycle("t3_clr", 4'b0000, 1'b1, 1'b1);
    repeat (3) cycle("t3_hold", 4'b1010, 1'b1, 1'b0);
    chk("t3_fp_ovf", 32'(overflow_w[1]), 32'd1);
    cycle("t3_re1", 4'b0010, 1'b1, 1'b0);
    repeat (4) cycle("t3_drain", 4'b0000, 1'b1, 1'b0);

    // output stalled on code 3 for five cycles, re-request of 3 while held
    cycle("t4_clr", 4'b0000, 1'b1, 1'b1);
    cycle("t4_req", 4'b1000, 1'b0, 1'b0);
    cycle("t4_load", 4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle("t4_stall", (k == 1) ? 4'b1000 : 4'b0000, 1'b0, 1'b0);
      chk($sformatf("t4_code%0d", k), 32'(code_out_w[0]), 32'd3);
      chk($sformatf("t4_valid%0d", k), 32'(code_valid_w[0]), 32'd1);
    end
    chk("t4_pend3", 32'(pending_w[0]), 32'b1000);
    chk("t4_no_ovf", 32'(overflow_w[0]), 32'd0);
    repeat (3) cycle("t4_drain", 4'b0000, 1'b1, 1'b0);

    // clear with pending bits and overflow set
    cycle("t5_clr", 4'b0000, 1'b1, 1'b1);
    cycle("t5_a", 4'b0001, 1'b0, 1'b0);
    cycle("t5_b", 4'b0110, 1'b0, 1'b0);
    cycle("t5_c", 4'b0110, 1'b0, 1'b0);
    chk("t5_pre_ovf", 32'(overflow_w[0]), 32'd1);
    cycle("t5_clear", 4'b1111, 1'b1, 1'b1);
    chk("t5_pending", 32'(pending_w[0]), 32'd0);
    chk("t5_valid", 32'(code_valid_w[0]), 32'd0);
    chk("t5_ovf", 32'(overflow_w[0]), 32'd0);
    cycle("t5_req0", 4'b0001, 1'b1, 1'b0);
    cycle("t5_out", 4'b0000, 1'b1, 1'b0);
    chk("t5_code", 32'(code_out_w[0]), 32'd0);

    // asynchronous reset between edges while holding
    cycle("t6_req", 4'b0110, 1'b0, 1'b0);
    cycle("t6_hold", 4'b0000, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid_rr", 32'(code_valid_w[0]), 32'd0);
    chk("t6_async_valid_fp", 32'(code_valid_w[1]), 32'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
    cycle("t6_req_all", 4'b1111, 1'b1, 1'b0);
    cycle("t6_first", 4'b0000, 1'b1, 1'b0);
    chk("t6_rr_restart", 32'(code_out_w[0]), 32'd0);
    repeat (4) cycle("t6_drain", 4'b0000, 1'b1, 1'b0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [3:0] r;
      r = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      cycle("rand", r, 1'($urandom_range(0, 1)), ($urandom_range(0, 40) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
